uart_comm_slv: RTL

- DSO-side end of the host command link; counterpart of the host UART master.
- Deserializes three 8N1 UART bytes from the host into one 24-bit command and presents it to the command dispatcher with a ready flag.
- Serializes single 8-bit response bytes (ACK/NAK, dump data, EEP/trigger reads) back to the host.
- Sits between the RX/TX pins and the command-processing FSM inside DSO_dig.

---
 rtl/dso_uart_pkg.sv | 40 ++++
 rtl/uart_comm_slv_if.sv | 38 +++
 rtl/uart_byte_rx.sv | 116 +++++++++++
 rtl/uart_comm_slv.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/dso_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dso_uart_pkg
// Brief    : Shared types and constants for the DSO host command link.
// Revision : 1.0 - initial release
// ============================================================================
package dso_uart_pkg;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_XMIT = 1'b1
    } tx_state_t;

    // Baud counters count BAUD_DIV-1 down to 0, so clog2 bits are enough.
    function automatic int baud_cnt_w(input int baud_div);
        return $clog2(baud_div);
    endfunction

    localparam logic [7:0] DUMP_CH  = 8'h01;
    localparam logic [7:0] CFG_GAIN = 8'h02;
    localparam logic [7:0] TRIG_LVL = 8'h03;
    localparam logic [7:0] TRIG_POS = 8'h04;
    localparam logic [7:0] SET_DEC  = 8'h05;
    localparam logic [7:0] TRIG_CFG = 8'h06;
    localparam logic [7:0] TRIG_RD  = 8'h07;
    localparam logic [7:0] EEP_WR   = 8'h08;
    localparam logic [7:0] EEP_RD   = 8'h09;

    localparam logic [7:0] ACK      = 8'hA5;
    localparam logic [7:0] NAK      = 8'hEE;

endpackage
`default_nettype wire

// File: rtl/uart_comm_slv_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_comm_slv_if
// Brief    : Dispatcher-side command/response bundle of the host UART link.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_comm_slv_if;

    logic [23:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp_data;
    logic        send_resp;
    logic        resp_sent;
    logic        tx_busy;

    modport slave (
        output cmd,
        output cmd_rdy,
        output resp_sent,
        output tx_busy,
        input  clr_cmd_rdy,
        input  resp_data,
        input  send_resp
    );

    modport master (
        input  cmd,
        input  cmd_rdy,
        input  resp_sent,
        input  tx_busy,
        output clr_cmd_rdy,
        output resp_data,
        output send_resp
    );

endinterface
`default_nettype wire

// File: rtl/uart_byte_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_byte_rx
// Brief    : 8N1 byte receiver: RX synchronizer, framing FSM, shift register.
// Revision : 1.0 - initial release
// ============================================================================
module uart_byte_rx
    import dso_uart_pkg::*;
#(
    parameter int BAUD_DIV = 2604
) (
    input  wire        clk,
    input  wire        rst_n,
    input  wire        i_rx,
    output logic [7:0] o_byte,
    output logic       o_byte_vld,
    output logic       o_frame_err,
    output logic       o_idle
);

    localparam int                 c_CNT_W = baud_cnt_w(BAUD_DIV);
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(BAUD_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_HALF  = c_CNT_W'(BAUD_DIV / 2 - 1);

    logic               r_rx_meta;
    logic               r_rx_sync;
    logic               r_rx_prev;
    rx_state_t          r_state,  w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt,    w_cnt_nxt;
    logic [2:0]         r_bit,    w_bit_nxt;
    logic [7:0]         r_shift,  w_shift_nxt;
    logic               w_vld;
    logic               w_ferr;

    // r_rx_prev is only the edge-detect history, not a synchronizer stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
            r_state   <= RX_IDLE;
            r_cnt     <= '0;
            r_bit     <= 3'd0;
            r_shift   <= 8'h00;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit     <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_vld       = 1'b0;
        w_ferr      = 1'b0;
        case (r_state)
            RX_IDLE: begin
                if (r_rx_prev && !r_rx_sync) begin
                    w_state_nxt = RX_START;
                    w_cnt_nxt   = c_HALF;
                end
            end
            RX_START: begin
                if (r_cnt == '0) begin
                    if (r_rx_sync) begin
                        w_state_nxt = RX_IDLE;
                    end else begin
                        w_state_nxt = RX_DATA;
                        w_cnt_nxt   = c_FULL;
                        w_bit_nxt   = 3'd0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            RX_DATA: begin
                if (r_cnt == '0) begin
                    w_shift_nxt = {r_rx_sync, r_shift[7:1]};
                    w_cnt_nxt   = c_FULL;
                    w_bit_nxt   = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = RX_STOP;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            RX_STOP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = RX_IDLE;
                    w_vld       = r_rx_sync;
                    w_ferr      = !r_rx_sync;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = RX_IDLE;
            end
        endcase
    end

    assign o_byte      = r_shift;
    assign o_byte_vld  = w_vld;
    assign o_frame_err = w_ferr;
    assign o_idle      = (r_state == RX_IDLE);

endmodule
`default_nettype wire

// File: rtl/uart_comm_slv.sv
`default_nettype none
// ============================================================================
// Module   : uart_comm_slv
// Brief    : DSO-side host link: 3-byte command assembly and response sender.
// Revision : 1.0 - initial release
// ============================================================================
module uart_comm_slv
    import dso_uart_pkg::*;
#(
    parameter int BAUD_DIV   = 2604,
    parameter int IB_TIMEOUT = 65535
) (
    input  wire            clk,
    input  wire            rst_n,
    input  wire            RX,
    output logic           TX,
    uart_comm_slv_if.slave bus
);

    localparam int                 c_CNT_W    = baud_cnt_w(BAUD_DIV);
    localparam logic [c_CNT_W-1:0] c_FULL     = c_CNT_W'(BAUD_DIV - 1);
    localparam int                 c_IB_W     = $clog2(IB_TIMEOUT + 1);
    localparam logic [c_IB_W-1:0]  c_IB_LAST  = c_IB_W'(IB_TIMEOUT - 1);

    logic [7:0]        w_rx_byte;
    logic              w_rx_vld;
    logic              w_rx_ferr;
    logic              w_rx_idle;

    logic [23:0]       r_cmd;
    logic              r_cmd_rdy;
    logic [1:0]        r_byte_cnt;
    logic [c_IB_W-1:0] r_ib_tmr;
    logic              w_ib_run;

    uart_byte_rx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_byte_rx (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_rx        (RX),
        .o_byte      (w_rx_byte),
        .o_byte_vld  (w_rx_vld),
        .o_frame_err (w_rx_ferr),
        .o_idle      (w_rx_idle)
    );

    // The gap timer only runs between bytes of a partially received command.
    assign w_ib_run = (r_byte_cnt != 2'd0) && w_rx_idle;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd      <= 24'h000000;
            r_cmd_rdy  <= 1'b0;
            r_byte_cnt <= 2'd0;
            r_ib_tmr   <= '0;
        end else begin
            if (w_rx_ferr) begin
                r_byte_cnt <= 2'd0;
            end else if (w_rx_vld) begin
                case (r_byte_cnt)
                    2'd0: begin
                        r_cmd[23:16] <= w_rx_byte;
                        r_byte_cnt   <= 2'd1;
                    end
                    2'd1: begin
                        r_cmd[15:8]  <= w_rx_byte;
                        r_byte_cnt   <= 2'd2;
                    end
                    2'd2: begin
                        r_cmd[7:0]   <= w_rx_byte;
                        r_byte_cnt   <= 2'd0;
                    end
                    default: begin
                        r_byte_cnt   <= 2'd0;
                    end
                endcase
            end else if (w_ib_run && (r_ib_tmr == c_IB_LAST)) begin
                r_byte_cnt <= 2'd0;
            end

            if (w_ib_run && (r_ib_tmr != c_IB_LAST)) begin
                r_ib_tmr <= r_ib_tmr + 1'b1;
            end else begin
                r_ib_tmr <= '0;
            end

            // Completion beats a simultaneous acknowledge.
            if (w_rx_vld && (r_byte_cnt == 2'd2)) begin
                r_cmd_rdy <= 1'b1;
            end else if ((w_rx_vld && (r_byte_cnt == 2'd0)) || bus.clr_cmd_rdy) begin
                r_cmd_rdy <= 1'b0;
            end
        end
    end

    assign bus.cmd     = r_cmd;
    assign bus.cmd_rdy = r_cmd_rdy;

    tx_state_t          r_tx_state,  w_tx_state_nxt;
    logic [9:0]         r_tx_shift,  w_tx_shift_nxt;
    logic [c_CNT_W-1:0] r_tx_cnt,    w_tx_cnt_nxt;
    logic [3:0]         r_tx_bit,    w_tx_bit_nxt;
    logic               r_resp_sent, w_resp_sent_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_state  <= TX_IDLE;
            r_tx_shift  <= '1;
            r_tx_cnt    <= '0;
            r_tx_bit    <= 4'd0;
            r_resp_sent <= 1'b0;
        end else begin
            r_tx_state  <= w_tx_state_nxt;
            r_tx_shift  <= w_tx_shift_nxt;
            r_tx_cnt    <= w_tx_cnt_nxt;
            r_tx_bit    <= w_tx_bit_nxt;
            r_resp_sent <= w_resp_sent_nxt;
        end
    end

    // Ones are shifted in behind the frame, so the line idles high on its own.
    always_comb begin
        w_tx_state_nxt  = r_tx_state;
        w_tx_shift_nxt  = r_tx_shift;
        w_tx_cnt_nxt    = r_tx_cnt;
        w_tx_bit_nxt    = r_tx_bit;
        w_resp_sent_nxt = r_resp_sent;
        case (r_tx_state)
            TX_IDLE: begin
                if (bus.send_resp) begin
                    w_tx_state_nxt  = TX_XMIT;
                    w_tx_shift_nxt  = {1'b1, bus.resp_data, 1'b0};
                    w_tx_cnt_nxt    = c_FULL;
                    w_tx_bit_nxt    = 4'd0;
                    w_resp_sent_nxt = 1'b0;
                end
            end
            TX_XMIT: begin
                if (r_tx_cnt == '0) begin
                    w_tx_shift_nxt = {1'b1, r_tx_shift[9:1]};
                    w_tx_cnt_nxt   = c_FULL;
                    w_tx_bit_nxt   = r_tx_bit + 4'd1;
                    if (r_tx_bit == 4'd9) begin
                        w_tx_state_nxt  = TX_IDLE;
                        w_resp_sent_nxt = 1'b1;
                    end
                end else begin
                    w_tx_cnt_nxt = r_tx_cnt - 1'b1;
                end
            end
            default: begin
                w_tx_state_nxt = TX_IDLE;
            end
        endcase
    end

    assign TX            = r_tx_shift[0];
    assign bus.tx_busy   = (r_tx_state == TX_XMIT);
    assign bus.resp_sent = r_resp_sent;

endmodule
`default_nettype wire
